// File: rtl/shift_reg_multi.sv
// Multi-lane shift register: DEPTH stages of WIDTH-bit words with per-stage valid and fill count.
// Optional macro SHIFT_REG_DIR_EN adds i_dir for reverse shift/rotate.
module shift_reg_multi #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [1:0]             i_mode,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_din_vld,
  input  logic [WIDTH*DEPTH-1:0] i_load,
`ifdef SHIFT_REG_DIR_EN
  input  logic                   i_dir,
`endif
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_dout_vld,
  output logic [WIDTH*DEPTH-1:0] o_taps,
  output logic [CNT_W-1:0]       o_fill,
  output logic                   o_full
);

  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CNT_W-1:0] r_fill;
  logic             r_full;

  logic [WIDTH-1:0] w_data_nxt [DEPTH];
  logic [DEPTH-1:0] w_vld_nxt;
  logic [CNT_W-1:0] w_fill_nxt;
  logic             w_rev;
  logic             w_vld_out;

`ifdef SHIFT_REG_DIR_EN
  assign w_rev = i_dir;
`else
  assign w_rev = 1'b0;
`endif

  assign w_vld_out = w_rev ? r_vld[0] : r_vld[DEPTH-1];

  always_comb begin
    w_data_nxt = r_data;
    w_vld_nxt  = r_vld;
    w_fill_nxt = r_fill;
    if (i_en) begin
      case (i_mode)
        MODE_SHIFT: begin
          if (!w_rev) begin
            for (int k = 1; k < DEPTH; k++) begin
              w_data_nxt[k] = r_data[k-1];
              w_vld_nxt[k]  = r_vld[k-1];
            end
            w_data_nxt[0] = i_din;
            w_vld_nxt[0]  = i_din_vld;
          end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
              w_data_nxt[k] = r_data[k+1];
              w_vld_nxt[k]  = r_vld[k+1];
            end
            w_data_nxt[DEPTH-1] = i_din;
            w_vld_nxt[DEPTH-1]  = i_din_vld;
          end
          // Only the in/out valid pair can move the count; both or neither leaves it alone.
          if (i_din_vld && !w_vld_out)
            w_fill_nxt = r_fill + CNT_W'(1);
          else if (!i_din_vld && w_vld_out)
            w_fill_nxt = r_fill - CNT_W'(1);
        end
        MODE_ROTATE: begin
          if (!w_rev) begin
            for (int k = 1; k < DEPTH; k++) begin
              w_data_nxt[k] = r_data[k-1];
              w_vld_nxt[k]  = r_vld[k-1];
            end
            w_data_nxt[0] = r_data[DEPTH-1];
            w_vld_nxt[0]  = r_vld[DEPTH-1];
          end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
              w_data_nxt[k] = r_data[k+1];
              w_vld_nxt[k]  = r_vld[k+1];
            end
            w_data_nxt[DEPTH-1] = r_data[0];
            w_vld_nxt[DEPTH-1]  = r_vld[0];
          end
        end
        MODE_LOAD: begin
          for (int k = 0; k < DEPTH; k++)
            w_data_nxt[k] = i_load[k*WIDTH +: WIDTH];
          w_vld_nxt  = '1;
          w_fill_nxt = CNT_W'(DEPTH);
        end
        MODE_CLEAR: begin
          for (int k = 0; k < DEPTH; k++)
            w_data_nxt[k] = '0;
          w_vld_nxt  = '0;
          w_fill_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        r_data[k] <= '0;
      r_vld  <= '0;
      r_fill <= '0;
      r_full <= 1'b0;
    end else begin
      r_data <= w_data_nxt;
      r_vld  <= w_vld_nxt;
      r_fill <= w_fill_nxt;
      r_full <= (w_fill_nxt == CNT_W'(DEPTH));
    end
  end

  always_comb begin
    o_taps = '0;
    for (int k = 0; k < DEPTH; k++)
      o_taps[k*WIDTH +: WIDTH] = r_data[k];
  end

  assign o_dout     = w_rev ? r_data[0] : r_data[DEPTH-1];
  assign o_dout_vld = w_vld_out;
  assign o_fill     = r_fill;
  assign o_full     = r_full;

endmodule

// File: tb/tb_shift_reg_multi.sv
// Self-checking bench for shift_reg_multi (WIDTH=8, DEPTH=4) against a queue-based model.
// Define SHIFT_REG_DIR_EN to also exercise reverse direction.
module tb_shift_reg_multi;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clk;
  logic                   rst_n;
  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       din;
  logic                   din_vld;
  logic [WIDTH*DEPTH-1:0] load;
  logic                   dir;
  logic [WIDTH-1:0]       dout;
  logic                   dout_vld;
  logic [WIDTH*DEPTH-1:0] taps;
  logic [CNT_W-1:0]       fill;
  logic                   full;

  int total = 0;
  int bad   = 0;

  shift_reg_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_mode     (mode),
    .i_din      (din),
    .i_din_vld  (din_vld),
    .i_load     (load),
`ifdef SHIFT_REG_DIR_EN
    .i_dir      (dir),
`endif
    .o_dout     (dout),
    .o_dout_vld (dout_vld),
    .o_taps     (taps),
    .o_fill     (fill),
    .o_full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue index k is stage k.
  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } ent_t;
  ent_t m_q[$];

  task automatic model_reset();
    m_q.delete();
    for (int k = 0; k < DEPTH; k++) m_q.push_back('0);
  endtask

  task automatic model_step(input logic e, input logic [1:0] md, input logic [WIDTH-1:0] di,
                            input logic dv, input logic [WIDTH*DEPTH-1:0] ld, input logic rv);
    ent_t x;
    if (!e) return;
    case (md)
      2'd0: begin
        x.v = dv; x.d = di;
        if (!rv) begin m_q.push_front(x); void'(m_q.pop_back()); end
        else     begin m_q.push_back(x);  void'(m_q.pop_front()); end
      end
      2'd1: begin
        if (!rv) begin x = m_q.pop_back();  m_q.push_front(x); end
        else     begin x = m_q.pop_front(); m_q.push_back(x);  end
      end
      2'd2: begin
        m_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
          x.v = 1'b1; x.d = ld[k*WIDTH +: WIDTH];
          m_q.push_back(x);
        end
      end
      default: model_reset();
    endcase
  endtask

  function automatic logic [WIDTH*DEPTH-1:0] m_taps();
    logic [WIDTH*DEPTH-1:0] t = '0;
    for (int k = 0; k < DEPTH; k++) t[k*WIDTH +: WIDTH] = m_q[k].d;
    return t;
  endfunction

  function automatic int m_fill();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += int'(m_q[k].v);
    return n;
  endfunction

  // Inputs are applied 1 time unit after an edge; outputs sampled 1 unit after the next edge.
  task automatic drive(input logic e, input logic [1:0] md, input logic [WIDTH-1:0] di,
                       input logic dv, input logic [WIDTH*DEPTH-1:0] ld, input logic rv);
    en = e; mode = md; din = di; din_vld = dv; load = ld; dir = rv;
    @(posedge clk); #1;
    model_step(e, md, di, dv, ld, rv);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; din = '0; din_vld = 1'b0; load = '0; dir = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (taps !== '0) begin bad++; $display("FAIL reset_taps got=%h exp=0", taps); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_dout_vld got=%b exp=0", dout_vld); end
    total++; if (fill !== '0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_shift_in();
    logic [WIDTH-1:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd0, v[i], 1'b1, '0, 1'b0);
    total++; if (taps !== 32'h11223344) begin bad++; $display("FAIL shift_taps got=%h exp=11223344", taps); end
    total++; if (dout !== 8'h11) begin bad++; $display("FAIL shift_dout got=%h exp=11", dout); end
    total++; if (dout_vld !== 1'b1) begin bad++; $display("FAIL shift_dout_vld got=%b exp=1", dout_vld); end
    total++; if (fill !== 3'd4) begin bad++; $display("FAIL shift_fill got=%0d exp=4", fill); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL shift_full got=%b exp=1", full); end
  endtask

  task automatic test_rotate();
    drive(1'b1, 2'd1, 8'hEE, 1'b0, '0, 1'b0);
    total++; if (taps !== 32'h22334411) begin bad++; $display("FAIL rot1_taps got=%h exp=22334411", taps); end
    total++; if (fill !== 3'd4) begin bad++; $display("FAIL rot1_fill got=%0d exp=4", fill); end
    repeat (3) drive(1'b1, 2'd1, 8'hEE, 1'b0, '0, 1'b0);
    total++; if (taps !== 32'h11223344) begin bad++; $display("FAIL rot4_taps got=%h exp=11223344", taps); end
  endtask

  task automatic test_hold();
    repeat (3) drive(1'b0, 2'd0, 8'hFF, 1'b1, 32'hDEADBEEF, 1'b0);
    total++; if (taps !== 32'h11223344) begin bad++; $display("FAIL hold_taps got=%h exp=11223344", taps); end
    total++; if (fill !== 3'd4) begin bad++; $display("FAIL hold_fill got=%0d exp=4", fill); end
  endtask

  task automatic test_load_drain();
    logic [WIDTH-1:0] ed [4] = '{8'hB2, 8'hC3, 8'hD4, 8'h00};
    logic [CNT_W-1:0] ef [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    drive(1'b1, 2'd2, 8'h00, 1'b0, 32'hA1B2C3D4, 1'b0);
    total++; if (taps !== 32'hA1B2C3D4) begin bad++; $display("FAIL load_taps got=%h exp=a1b2c3d4", taps); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 8'h00, 1'b0, '0, 1'b0);
      total++; if (dout !== ed[i]) begin bad++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, dout, ed[i]); end
      total++; if (fill !== ef[i]) begin bad++; $display("FAIL drain_fill[%0d] got=%0d exp=%0d", i, fill, ef[i]); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL drain_full[%0d] got=%b exp=0", i, full); end
    end
    drive(1'b1, 2'd1, 8'h00, 1'b0, '0, 1'b0);
    total++; if (fill !== 3'd0) begin bad++; $display("FAIL rot_empty_fill got=%0d exp=0", fill); end
  endtask

  task automatic test_full_and_async_reset();
    drive(1'b1, 2'd2, 8'h00, 1'b0, 32'h01020304, 1'b0);
    drive(1'b1, 2'd0, 8'h99, 1'b1, '0, 1'b0);
    total++; if (fill !== 3'd4) begin bad++; $display("FAIL full_shift_fill got=%0d exp=4", fill); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_shift_full got=%b exp=1", full); end
    total++; if (taps !== 32'h02030499) begin bad++; $display("FAIL full_shift_taps got=%h exp=02030499", taps); end
    rst_n = 1'b0;
    #2;
    total++; if (taps !== '0) begin bad++; $display("FAIL arst_taps got=%h exp=0", taps); end
    total++; if (dout !== '0) begin bad++; $display("FAIL arst_dout got=%h exp=0", dout); end
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL arst_dout_vld got=%b exp=0", dout_vld); end
    total++; if (fill !== '0) begin bad++; $display("FAIL arst_fill got=%0d exp=0", fill); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL arst_full got=%b exp=0", full); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

`ifdef SHIFT_REG_DIR_EN
  task automatic test_dir();
    drive(1'b1, 2'd2, 8'h00, 1'b0, 32'h11223344, 1'b0);
    drive(1'b1, 2'd0, 8'h55, 1'b1, '0, 1'b1);
    total++; if (taps !== 32'h55112233) begin bad++; $display("FAIL dir_taps got=%h exp=55112233", taps); end
    total++; if (dout !== 8'h33) begin bad++; $display("FAIL dir_dout got=%h exp=33", dout); end
    drive(1'b1, 2'd1, 8'h00, 1'b0, '0, 1'b1);
    total++; if (taps !== 32'h33551122) begin bad++; $display("FAIL dir_rot_taps got=%h exp=33551122", taps); end
  endtask
`endif

  task automatic test_random();
    logic             e, dv, rv;
    logic [1:0]       md;
    int               r;
    logic [WIDTH-1:0] ed;
    logic             ev;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 7) != 0);
      r  = $urandom_range(0, 9);
      md = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      dv = $urandom_range(0, 3) != 0;
`ifdef SHIFT_REG_DIR_EN
      rv = $urandom_range(0, 1) != 0;
`else
      rv = 1'b0;
`endif
      drive(e, md, WIDTH'($urandom), dv, (WIDTH*DEPTH)'($urandom), rv);
      ed = rv ? m_q[0].d : m_q[DEPTH-1].d;
      ev = rv ? m_q[0].v : m_q[DEPTH-1].v;
      total++; if (taps !== m_taps()) begin bad++; $display("FAIL rnd_taps[%0d] got=%h exp=%h", i, taps, m_taps()); end
      total++; if (dout !== ed) begin bad++; $display("FAIL rnd_dout[%0d] got=%h exp=%h", i, dout, ed); end
      total++; if (dout_vld !== ev) begin bad++; $display("FAIL rnd_dout_vld[%0d] got=%b exp=%b", i, dout_vld, ev); end
      total++; if (int'(fill) !== m_fill()) begin bad++; $display("FAIL rnd_fill[%0d] got=%0d exp=%0d", i, fill, m_fill()); end
      total++; if (full !== (m_fill() == DEPTH)) begin bad++; $display("FAIL rnd_full[%0d] got=%b exp=%b", i, full, m_fill() == DEPTH); end
    end
  endtask

  initial begin
    test_reset();
    test_shift_in();
    test_rotate();
    test_hold();
    test_load_drain();
    test_full_and_async_reset();
`ifdef SHIFT_REG_DIR_EN
    test_dir();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
